// File: rtl/mod_inv_pkg.sv
// Shared definitions for the sequential modular-inverse engine.
//   state_t        FSM encoding (IDLE, CALC, DONE)
//   max_iter(w)    worst-case CALC cycles for a w-bit job (4*w+2)
//   FIXED_LAT_OFS  extra cycle on top of max_iter in the fixed-latency build
package mod_inv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int FIXED_LAT_OFS = 1;

  function automatic int max_iter(input int w);
    return 4 * w + 2;
  endfunction

endpackage

// File: rtl/mod_inv_step.sv
// One iteration of binary extended Euclid, purely combinational.
// Invariants kept by the caller: x1*a == u and x2*a == v (mod m), x1,x2 in [0,m-1].
//   u, v, x1, x2, m   current state and (odd) modulus
//   u_nxt..x2_nxt     state after this step (unchanged when done)
//   done              job finished this step
//   err               finished with no inverse (gcd > 1)
//   res               inverse when done && !err, else 0
module mod_inv_step #(
  parameter int IP_WIDTH = 6
) (
  input  logic [IP_WIDTH-1:0] u,
  input  logic [IP_WIDTH-1:0] v,
  input  logic [IP_WIDTH-1:0] x1,
  input  logic [IP_WIDTH-1:0] x2,
  input  logic [IP_WIDTH-1:0] m,
  output logic [IP_WIDTH-1:0] u_nxt,
  output logic [IP_WIDTH-1:0] v_nxt,
  output logic [IP_WIDTH-1:0] x1_nxt,
  output logic [IP_WIDTH-1:0] x2_nxt,
  output logic [IP_WIDTH-1:0] res,
  output logic                done,
  output logic                err
);

  // x/2 mod m; m is odd, so an odd x is made even by adding m first.
  function automatic logic [IP_WIDTH-1:0] half(input logic [IP_WIDTH-1:0] x,
                                               input logic [IP_WIDTH-1:0] md);
    if (!x[0]) return x >> 1;
    return IP_WIDTH'(({1'b0, x} + {1'b0, md}) >> 1);
  endfunction

  // (a-b) mod m for a,b in [0,m-1]; the extra bit is the borrow.
  function automatic logic [IP_WIDTH-1:0] mod_sub(input logic [IP_WIDTH-1:0] a,
                                                  input logic [IP_WIDTH-1:0] b,
                                                  input logic [IP_WIDTH-1:0] md);
    logic [IP_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[IP_WIDTH] ? IP_WIDTH'(d + {1'b0, md}) : d[IP_WIDTH-1:0];
  endfunction

  localparam logic [IP_WIDTH-1:0] ONE = IP_WIDTH'(1);

  always_comb begin
    u_nxt  = u;
    v_nxt  = v;
    x1_nxt = x1;
    x2_nxt = x2;
    res    = '0;
    done   = 1'b0;
    err    = 1'b0;
    if (u == ONE) begin
      done = 1'b1;
      res  = x1;
    end else if (v == ONE) begin
      done = 1'b1;
      res  = x2;
    end else if (u == '0 || v == '0) begin
      done = 1'b1;
      err  = 1'b1;
    end else if (!u[0]) begin
      u_nxt  = u >> 1;
      x1_nxt = half(x1, m);
    end else if (!v[0]) begin
      v_nxt  = v >> 1;
      x2_nxt = half(x2, m);
    end else if (u >= v) begin
      u_nxt  = u - v;
      x1_nxt = mod_sub(x1, x2, m);
    end else begin
      v_nxt  = v - u;
      x2_nxt = mod_sub(x2, x1, m);
    end
  end

endmodule

// File: rtl/mod_inv_seq.sv
// Sequential modular inverse: OUT_INV = IN_1^-1 mod IN_2, one Euclid step per cycle.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (ready only in IDLE)
//   IN_1, IN_2      value a and odd modulus m
//   out_valid/ready result handshake; result held until consumed
//   OUT_INV         inverse in [1,m-1], 0 on error
//   out_err         no inverse, or illegal operands (m<3, m even, a==0, a>=m)
// Build option MOD_INV_FIXED_LAT_EN: every job (legal or not) reports exactly
// 4*IP_WIDTH+3 cycles after the accept edge; otherwise latency is data dependent.
module mod_inv_seq
  import mod_inv_pkg::*;
#(
  parameter int IP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IP_WIDTH-1:0] IN_1,
  input  logic [IP_WIDTH-1:0] IN_2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IP_WIDTH-1:0] OUT_INV,
  output logic                out_err
);

  localparam int W = IP_WIDTH;

  state_t       state;
  logic [W-1:0] m_r, u, v, x1, x2;
  logic [W-1:0] u_n, v_n, x1_n, x2_n, s_res;
  logic         s_done, s_err;
  logic         illegal;

  assign illegal = (IN_2 < W'(3)) || !IN_2[0] || (IN_1 == '0) || (IN_1 >= IN_2);

  mod_inv_step #(.IP_WIDTH(W)) u_step (
    .u(u), .v(v), .x1(x1), .x2(x2), .m(m_r),
    .u_nxt(u_n), .v_nxt(v_n), .x1_nxt(x1_n), .x2_nxt(x2_n),
    .res(s_res), .done(s_done), .err(s_err)
  );

`ifdef MOD_INV_FIXED_LAT_EN
  // The accept edge is one cycle of the total, the rest are spent in CALC.
  localparam int CALC_CYC = max_iter(W) + FIXED_LAT_OFS - 1;
  localparam int CW       = $clog2(CALC_CYC);
  logic [CW-1:0] cnt;
  logic          fin;   // algorithm finished, result parked until cnt expires
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      OUT_INV   <= '0;
      out_err   <= 1'b0;
      m_r       <= '0;
      u         <= '0;
      v         <= '0;
      x1        <= '0;
      x2        <= '0;
`ifdef MOD_INV_FIXED_LAT_EN
      cnt       <= '0;
      fin       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          m_r      <= IN_2;
          u        <= IN_1;
          v        <= IN_2;
          x1       <= W'(1);
          x2       <= '0;
          in_ready <= 1'b0;
          OUT_INV  <= '0;
          out_err  <= illegal;
`ifdef MOD_INV_FIXED_LAT_EN
          cnt      <= '0;
          fin      <= illegal;
          state    <= CALC;
`else
          out_valid <= illegal;
          state     <= illegal ? DONE : CALC;
`endif
        end
        CALC: begin
`ifdef MOD_INV_FIXED_LAT_EN
          cnt <= cnt + 1'b1;
          if (!fin) begin
            if (s_done) begin
              fin     <= 1'b1;
              OUT_INV <= s_res;
              out_err <= s_err;
            end else begin
              u  <= u_n;
              v  <= v_n;
              x1 <= x1_n;
              x2 <= x2_n;
            end
          end
          if (cnt == CW'(CALC_CYC - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
`else
          if (s_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            OUT_INV   <= s_res;
            out_err   <= s_err;
          end else begin
            u  <= u_n;
            v  <= v_n;
            x1 <= x1_n;
            x2 <= x2_n;
          end
`endif
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_seq.sv
// Directed bench for mod_inv_seq: instances at widths 6, 5, 7 and 12.
// Latency is counted in clock edges from the accept edge (inclusive) until
// out_valid is seen high, so an illegal job is 1 and a=1 is 2.
module tb_mod_inv_seq;

  localparam int NI = 4;
  localparam int WS [NI] = '{6, 5, 7, 12};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic [NI-1:0] in_valid_v = '0;
  logic [NI-1:0] in_ready_v, out_valid_v, out_err_v;
  logic [15:0] inv_v [NI];

  int n_chk = 0, n_err = 0;
  int xfer0 = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = WS[g];
    logic [W-1:0] inv;
    mod_inv_seq #(.IP_WIDTH(W)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .IN_1(in1[W-1:0]), .IN_2(in2[W-1:0]),
      .out_valid(out_valid_v[g]), .out_ready(out_ready),
      .OUT_INV(inv), .out_err(out_err_v[g])
    );
    assign inv_v[g] = 16'(inv);
  end

  always @(posedge clk) if (out_valid_v[0] && out_ready) xfer0 <= xfer0 + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_inv(input int a, input int m);
    for (int x = 1; x < m; x++) if ((a * x) % m == 1) return x;
    return 0;
  endfunction

  // kind: 0 legal, 1 illegal operands, 2 a==1
  task automatic chk_lat(input string tag, input int k, input int lat, input int kind);
`ifdef MOD_INV_FIXED_LAT_EN
    chk(tag, lat, 4 * WS[k] + 3);
`else
    case (kind)
      1:       chk(tag, lat, 1);
      2:       chk(tag, lat, 2);
      default: chk(tag, int'(lat <= 4 * WS[k] + 2), 1);
    endcase
`endif
  endtask

  task automatic start_job(input int k, input int a, input int m);
    in1 = 16'(a);
    in2 = 16'(m);
    in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat, output int res, output int err);
    lat = 1;
    while (!out_valid_v[k] && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid_v[k]) chk("timeout", 0, 1);
    res = int'(inv_v[k]);
    err = int'(out_err_v[k]);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_job(input int k, input int a, input int m,
                         output int lat, output int res, output int err);
    start_job(k, a, m);
    wait_out(k, lat, res, err);
    consume();
  endtask

  task automatic sweep(input int k, input int m);
    int lat, res, err;
    for (int a = 1; a < m; a++) begin
      run_job(k, a, m, lat, res, err);
      chk($sformatf("sweep_w%0d_m%0d_a%0d_inv", WS[k], m, a), res, ref_inv(a, m));
      chk($sformatf("sweep_w%0d_m%0d_a%0d_err", WS[k], m, a), err, 0);
      chk_lat($sformatf("sweep_w%0d_m%0d_a%0d_lat", WS[k], m, a), k, lat, (a == 1) ? 2 : 0);
    end
  endtask

  initial begin
    int lat, res, err, x_before;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready_v[0]), 1);
    chk("rst_out_valid", int'(out_valid_v[0]), 0);
    chk("rst_out_inv", int'(inv_v[0]), 0);
    chk("rst_out_err", int'(out_err_v[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(0, 3, 7, lat, res, err);
    chk("a3_m7_inv", res, 5);
    chk("a3_m7_err", err, 0);
    chk_lat("a3_m7_lat", 0, lat, 0);
    chk("after_xfer_in_ready", int'(in_ready_v[0]), 1);
    chk("after_xfer_out_valid", int'(out_valid_v[0]), 0);

    run_job(0, 10, 61, lat, res, err);
    chk("a10_m61_inv", res, 55);
    chk("a10_m61_err", err, 0);
    chk_lat("a10_m61_lat", 0, lat, 0);

    run_job(0, 1, 61, lat, res, err);
    chk("a1_m61_inv", res, 1);
    chk_lat("a1_m61_lat", 0, lat, 2);

    run_job(0, 6, 9, lat, res, err);
    chk("a6_m9_err", err, 1);
    chk("a6_m9_inv", res, 0);
    chk_lat("a6_m9_lat", 0, lat, 0);

    run_job(0, 0, 7, lat, res, err);
    chk("a0_m7_err", err, 1);
    chk("a0_m7_inv", res, 0);
    chk_lat("a0_m7_lat", 0, lat, 1);

    run_job(0, 3, 8, lat, res, err);
    chk("m8_err", err, 1);
    chk("m8_inv", res, 0);
    chk_lat("m8_lat", 0, lat, 1);

    run_job(0, 7, 7, lat, res, err);
    chk("a_eq_m_err", err, 1);
    chk_lat("a_eq_m_lat", 0, lat, 1);

    run_job(0, 1, 1, lat, res, err);
    chk("m1_err", err, 1);
    chk_lat("m1_lat", 0, lat, 1);

    // Backpressure: result must hold while out_ready stays low.
    x_before = xfer0;
    start_job(0, 3, 7);
    wait_out(0, lat, res, err);
    chk("bp_first_inv", res, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i), int'(out_valid_v[0]), 1);
      chk($sformatf("bp_hold%0d_inv", i), int'(inv_v[0]), 5);
      chk($sformatf("bp_hold%0d_err", i), int'(out_err_v[0]), 0);
      chk($sformatf("bp_hold%0d_in_ready", i), int'(in_ready_v[0]), 0);
    end
    consume();
    chk("bp_drop_valid", int'(out_valid_v[0]), 0);
    chk("bp_in_ready", int'(in_ready_v[0]), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_transfer", xfer0 - x_before, 1);

    // Reset in the middle of CALC discards the job.
    start_job(0, 3, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready_v[0]), 1);
    chk("midrst_out_valid", int'(out_valid_v[0]), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_output", int'(out_valid_v[0]), 0);
    run_job(0, 3, 7, lat, res, err);
    chk("midrst_new_inv", res, 5);
    chk("midrst_new_err", err, 0);

    sweep(1, 31);
    sweep(2, 127);
    sweep(3, 1021);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
